// File: rtl/push_pulse_gen.sv
// push_pulse_gen: per-channel sync, debounce, edge-select and auto-repeat push-button pulses
module push_pulse_gen #(
    parameter int CHANNELS   = 4,
    parameter int DB_CYCLES  = 4,
    parameter int REP_DELAY  = 16,
    parameter int REP_PERIOD = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic [CHANNELS-1:0] push,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] sig
);
    localparam int CW   = $clog2(DB_CYCLES + 1);
    localparam int RMAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);
    localparam logic [RW-1:0] RD_LAST = RW'(REP_DELAY - 1);
    localparam logic [RW-1:0] RP_LAST = RW'(REP_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} st_t;

    logic [CHANNELS-1:0] s1_q, s2_q, level_q, level_d, sig_q, sig_d, acc, rep;
    logic [1:0]          mode_q;
    logic [CW-1:0]       cnt_q [CHANNELS];
    logic [CW-1:0]       cnt_d [CHANNELS];
    logic [RW-1:0]       rc_q  [CHANNELS];
    logic [RW-1:0]       rc_d  [CHANNELS];
    st_t                 st_q  [CHANNELS];
    st_t                 st_d  [CHANNELS];
    logic                mode_chg, run;

    // Debounce accept, edge select and auto-repeat next-state per channel; a mode change blanks one cycle
    always_comb begin
        mode_chg = mode != mode_q;
        run      = en && !mode_chg && mode_q == 2'b11;
        acc      = '0;
        rep      = '0;
        level_d  = level_q;
        sig_d    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            acc[i]     = s2_q[i] != level_q[i] && cnt_q[i] == DB_LAST;
            level_d[i] = acc[i] ? s2_q[i] : level_q[i];
            cnt_d[i]   = (s2_q[i] == level_q[i] || acc[i]) ? '0 : cnt_q[i] + 1'b1;
            st_d[i]    = st_q[i];
            rc_d[i]    = rc_q[i];
            if (!run) begin
                st_d[i] = IDLE;
                rc_d[i] = '0;
            end else if (st_q[i] == IDLE) begin
                if (acc[i] && s2_q[i]) begin
                    st_d[i] = DELAY;
                    rc_d[i] = '0;
                end
            end else if (acc[i]) begin
                st_d[i] = IDLE;
                rc_d[i] = '0;
            end else if (rc_q[i] == ((st_q[i] == DELAY) ? RD_LAST : RP_LAST)) begin
                rep[i]  = 1'b1;
                st_d[i] = REPEAT;
                rc_d[i] = '0;
            end else begin
                rc_d[i] = rc_q[i] + 1'b1;
            end
            sig_d[i] = en && !mode_chg &&
                       ((mode_q == 2'b10) ? acc[i] :
                        (mode_q == 2'b01) ? (acc[i] && !s2_q[i]) :
                                            ((acc[i] && s2_q[i]) || rep[i]));
        end
    end

    // All state registered on clk, cleared asynchronously by rst_n
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= '0;
            s2_q    <= '0;
            level_q <= '0;
            sig_q   <= '0;
            mode_q  <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
                rc_q[i]  <= '0;
                st_q[i]  <= IDLE;
            end
        end else begin
            s1_q    <= push;
            s2_q    <= s1_q;
            level_q <= level_d;
            sig_q   <= sig_d;
            mode_q  <= mode;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= cnt_d[i];
                rc_q[i]  <= rc_d[i];
                st_q[i]  <= st_d[i];
            end
        end
    end

    assign level = level_q;
    assign sig   = sig_q;
endmodule

// File: tb/tb_push_pulse_gen.sv
// tb_push_pulse_gen: directed checks of debounce latency, edge modes, auto-repeat, mode change and async reset
`timescale 1ns/1ps
module tb_push_pulse_gen;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic [1:0] push;
    logic [1:0] level;
    logic [1:0] sig;
    int         total = 0;
    int         bad = 0;

    push_pulse_gen #(.CHANNELS(2), .DB_CYCLES(4), .REP_DELAY(16), .REP_PERIOD(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .push(push), .level(level), .sig(sig)
    );

    // 200 ns period, rising edges at 100, 300, 500 ...
    always #100 clk = ~clk;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; mode = 2'b00; push = 2'b00;
        // 1: reset state, then rising accept 5 edges after the sampling edge (300 ns)
        #50;
        chk("rst_level", level, 2'b00);
        chk("rst_sig", sig, 2'b00);
        #100 rst_n = 1'b1;
        #135 push = 2'b01;
        cyc(5);
        chk("t1_pre_sig", sig, 2'b00);
        chk("t1_pre_level", level, 2'b00);
        cyc(1);
        chk("t1_sig", sig, 2'b01);
        chk("t1_level", level, 2'b01);
        cyc(1);
        chk("t1_sig_one_cycle", sig, 2'b00);
        chk("t1_level_held", level, 2'b01);
        // 2: release without pulse in rising mode, then a 3-cycle glitch is discarded
        push = 2'b00;
        for (int c = 0; c < 6; c++) begin
            cyc(1);
            chk("t2_release_sig", sig, 2'b00);
        end
        chk("t2_release_level", level, 2'b00);
        push = 2'b01;
        cyc(3);
        push = 2'b00;
        for (int c = 0; c < 10; c++) begin
            cyc(1);
            chk("t2_glitch_level", level, 2'b00);
            chk("t2_glitch_sig", sig, 2'b00);
        end
        // 3: both-edge mode, one pulse per accept
        mode = 2'b10;
        cyc(2);
        push = 2'b01;
        cyc(5);
        chk("t3_press_pre", sig, 2'b00);
        cyc(1);
        chk("t3_press_sig", sig, 2'b01);
        chk("t3_press_level", level, 2'b01);
        cyc(1);
        chk("t3_press_width", sig, 2'b00);
        cyc(3);
        push = 2'b00;
        cyc(5);
        chk("t3_rel_pre", sig, 2'b00);
        chk("t3_rel_pre_level", level, 2'b01);
        cyc(1);
        chk("t3_rel_sig", sig, 2'b01);
        chk("t3_rel_level", level, 2'b00);
        cyc(1);
        chk("t3_rel_width", sig, 2'b00);
        // 4: auto-repeat on channel 1: accept at c=6, repeats +16,+24,+32,+40, release accepted at c=50
        mode = 2'b11;
        push = 2'b10;
        for (int c = 1; c <= 60; c++) begin
            cyc(1);
            chk("t4_sig", sig, (c == 6 || c == 22 || c == 30 || c == 38 || c == 46) ? 2'b10 : 2'b00);
            chk("t4_level", level, (c >= 6 && c < 50) ? 2'b10 : 2'b00);
            if (c == 44) push = 2'b00;
        end
        // 5: simultaneous press on both channels, then mode changes with no replay
        mode = 2'b00;
        cyc(2);
        push = 2'b11;
        cyc(5);
        chk("t5_pre", sig, 2'b00);
        cyc(1);
        chk("t5_both_sig", sig, 2'b11);
        chk("t5_both_level", level, 2'b11);
        cyc(1);
        chk("t5_both_width", sig, 2'b00);
        mode = 2'b10;
        for (int c = 0; c < 4; c++) begin
            cyc(1);
            chk("t5_no_replay", sig, 2'b00);
        end
        push = 2'b00;
        cyc(5);
        mode = 2'b01;
        cyc(1);
        chk("t5_chg_suppress", sig, 2'b00);
        chk("t5_chg_level", level, 2'b00);
        cyc(1);
        chk("t5_chg_after", sig, 2'b00);
        // 6: async reset mid-repeat, then fresh accept after release
        mode = 2'b11;
        push = 2'b01;
        for (int c = 1; c <= 30; c++) begin
            cyc(1);
            chk("t6_rep_sig", sig, (c == 6 || c == 22 || c == 30) ? 2'b01 : 2'b00);
        end
        #20 rst_n = 1'b0;
        #1;
        chk("t6_async_sig", sig, 2'b00);
        chk("t6_async_level", level, 2'b00);
        #20 rst_n = 1'b1;
        cyc(5);
        chk("t6_post_pre_sig", sig, 2'b00);
        chk("t6_post_pre_level", level, 2'b00);
        cyc(1);
        chk("t6_post_sig", sig, 2'b01);
        chk("t6_post_level", level, 2'b01);
        cyc(1);
        chk("t6_post_width", sig, 2'b00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
